// File: rtl/lane_phase_scheduler_pkg.sv
// Shared types for the lane phase scheduler: light codes, phase states, lane index width.
package traffic_pkg;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 2;

  typedef enum logic [1:0] {
    LIGHT_RED    = 2'b00,
    LIGHT_YELLOW = 2'b01,
    LIGHT_GREEN  = 2'b10
  } light_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GREEN   = 2'd1,
    YELLOW  = 2'd2,
    ALL_RED = 2'd3
  } phase_e;

  // Light vector with one lane showing the given code and all others red.
  function automatic logic [2*NUM_LANES-1:0] lane_code(input logic [LANE_W-1:0] lane,
                                                       input light_e code);
    return (2*NUM_LANES)'(code) << {lane, 1'b0};
  endfunction

endpackage

// File: rtl/lane_phase_scheduler_if.sv
// Sensor inputs and light-driver outputs of the lane phase scheduler.
interface lane_phase_scheduler_if;
  import traffic_pkg::*;

  logic                   tick_i;
  logic [NUM_LANES-1:0]   demand_i;
  logic [NUM_LANES-1:0]   congest_i;
  logic [2*NUM_LANES-1:0] lane_lights_o;
  logic [LANE_W-1:0]      active_lane_o;
  logic                   phase_busy_o;
  logic [1:0]             ext_count_o;

  modport master (
    output tick_i, demand_i, congest_i,
    input  lane_lights_o, active_lane_o, phase_busy_o, ext_count_o
  );

  modport slave (
    input  tick_i, demand_i, congest_i,
    output lane_lights_o, active_lane_o, phase_busy_o, ext_count_o
  );
endinterface

// File: rtl/lane_phase_scheduler_arb.sv
// Combinational round-robin lane picker; congested requests win over plain ones.
// With STARVATION_GUARD_EN a starved class ranks above congested.
module lane_rr_arbiter
  import traffic_pkg::*;
(
  input  logic [NUM_LANES-1:0] req_i,
  input  logic [NUM_LANES-1:0] pri_i,
`ifdef STARVATION_GUARD_EN
  input  logic [NUM_LANES-1:0] starve_i,
`endif
  input  logic [LANE_W-1:0]    rr_ptr_i,
  output logic                 grant_valid_o,
  output logic [LANE_W-1:0]    grant_idx_o
);

  logic [NUM_LANES-1:0] hi_req;
  logic [NUM_LANES-1:0] cls_req;
  logic [LANE_W-1:0]    idx;

  always_comb begin
    hi_req = req_i & pri_i;
`ifdef STARVATION_GUARD_EN
    if ((req_i & starve_i) != '0)
      cls_req = req_i & starve_i;
    else
`endif
    if (hi_req != '0)
      cls_req = hi_req;
    else
      cls_req = req_i;
  end

  // Walk from the farthest offset down so the nearest candidate after rr_ptr wins.
  always_comb begin
    grant_valid_o = |cls_req;
    grant_idx_o   = rr_ptr_i;
    idx           = rr_ptr_i;
    for (int k = NUM_LANES; k >= 1; k--) begin
      idx = rr_ptr_i + LANE_W'(k);
      if (cls_req[idx]) grant_idx_o = idx;
    end
  end

endmodule

// File: rtl/lane_phase_scheduler.sv
// Green/yellow/all-red phase sequencer for a 4-lane intersection with bounded green extensions.
// Optional STARVATION_GUARD_EN adds per-lane skip counters that promote long-waiting lanes.
//
// state   | meaning
// IDLE    | all red, no phase running, waiting for any demand
// GREEN   | active lane green; min time then extensions or rest
// YELLOW  | active lane yellow
// ALL_RED | clearance before the next grant decision
module lane_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int GREEN_MIN = 10,
  parameter int GREEN_EXT = 5,
  parameter int MAX_EXT   = 2,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 1,
  parameter int CNT_W     = 8
) (
  input logic                 clk,
  input logic                 rst,
  lane_phase_scheduler_if.slave bus
);

  phase_e                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [LANE_W-1:0]      lane_q;
  logic [LANE_W-1:0]      rr_ptr_q;
  logic [1:0]             ext_q;
  logic [2*NUM_LANES-1:0] lights_q;
  logic                   busy_q;

  logic                   grant_valid;
  logic [LANE_W-1:0]      grant_idx;
  logic                   expire;
  logic                   decide;
  logic                   others_demand;

  assign expire        = bus.tick_i && (cnt_q == CNT_W'(1));
  assign others_demand = (bus.demand_i & ~(NUM_LANES'(1) << lane_q)) != '0;
  assign decide        = grant_valid && ((state_q == IDLE) || (state_q == ALL_RED && expire));

`ifdef STARVATION_GUARD_EN
  logic [NUM_LANES-1:0][1:0] skip_q;
  logic [NUM_LANES-1:0][1:0] skip_d;
  logic [NUM_LANES-1:0]      starve;

  always_comb begin
    skip_d = skip_q;
    for (int i = 0; i < NUM_LANES; i++) begin
      starve[i] = (skip_q[i] == 2'd3);
      if (decide) begin
        if (LANE_W'(i) == grant_idx)
          skip_d[i] = 2'd0;
        else if (bus.demand_i[i] && skip_q[i] != 2'd3)
          skip_d[i] = skip_q[i] + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) skip_q <= '0;
    else     skip_q <= skip_d;
  end
`endif

  lane_rr_arbiter u_arb (
    .req_i         (bus.demand_i),
    .pri_i         (bus.congest_i),
`ifdef STARVATION_GUARD_EN
    .starve_i      (starve),
`endif
    .rr_ptr_i      (rr_ptr_q),
    .grant_valid_o (grant_valid),
    .grant_idx_o   (grant_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      lane_q   <= '0;
      rr_ptr_q <= LANE_W'(NUM_LANES - 1);
      ext_q    <= '0;
      lights_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, ALL_RED: begin
          if (decide) begin
            state_q  <= GREEN;
            lane_q   <= grant_idx;
            rr_ptr_q <= grant_idx;
            cnt_q    <= CNT_W'(GREEN_MIN);
            ext_q    <= '0;
            lights_q <= lane_code(grant_idx, LIGHT_GREEN);
            busy_q   <= 1'b1;
          end else if (state_q == ALL_RED && expire) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (state_q == ALL_RED && bus.tick_i) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        GREEN: begin
          if (expire) begin
            if (bus.congest_i[lane_q] && int'(ext_q) < MAX_EXT) begin
              cnt_q <= CNT_W'(GREEN_EXT);
              ext_q <= ext_q + 2'd1;
            end else if (bus.demand_i[lane_q] && !others_demand) begin
              // Rest in green while the active lane is the only one asking.
              cnt_q <= CNT_W'(GREEN_EXT);
            end else begin
              state_q  <= YELLOW;
              cnt_q    <= CNT_W'(YELLOW_T);
              lights_q <= lane_code(lane_q, LIGHT_YELLOW);
            end
          end else if (bus.tick_i) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        YELLOW: begin
          if (expire) begin
            state_q  <= ALL_RED;
            cnt_q    <= CNT_W'(ALLRED_T);
            lights_q <= '0;
          end else if (bus.tick_i) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.lane_lights_o = lights_q;
  assign bus.active_lane_o = lane_q;
  assign bus.phase_busy_o  = busy_q;
  assign bus.ext_count_o   = ext_q;

endmodule
